fifo_rd_ctrl: RTL and testbench

FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

---
 rtl/fifo_rd_ctrl_if.sv | 24 ++
 rtl/fifo_rd_ctrl.sv | 62 ++++++
 tb/tb_fifo_rd_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_ctrl_if.sv
// fifo_rd_ctrl_if: read-side FIFO bus between controller, memory, write-pointer sync and consumer
interface fifo_rd_ctrl_if #(
    parameter int ADDRSIZE = 4,
    parameter int DATASIZE = 8
);
    logic [ADDRSIZE:0]   rq2_wptr;
    logic [ADDRSIZE:0]   rptr;
    logic [ADDRSIZE:0]   rlevel;
    logic [ADDRSIZE-1:0] raddr;
    logic                ren;
    logic                rempty;
    logic                dout_valid;
    logic                dout_ready;
    logic [DATASIZE-1:0] rdata_mem;
    logic [DATASIZE-1:0] dout;
    modport master (
        input  rq2_wptr, rdata_mem, dout_ready,
        output rptr, raddr, ren, dout, dout_valid, rempty, rlevel
    );
    modport slave (
        output rq2_wptr, rdata_mem, dout_ready,
        input  rptr, raddr, ren, dout, dout_valid, rempty, rlevel
    );
endinterface

// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: async FIFO read controller with Gray pointer, level and 2-entry output buffer
module fifo_rd_ctrl #(
    parameter int ADDRSIZE = 4,
    parameter int DATASIZE = 8
) (
    input logic          rclk,
    input logic          rrst_n,
    fifo_rd_ctrl_if.master bus
);
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
    state_t              state, state_n, after_pop;
    logic [ADDRSIZE:0]   rbin, rbin_next, rgray_next, wbin;
    logic [DATASIZE-1:0] head, skid, head_n, skid_n;
    logic                pend, pop;
    genvar i;
    generate
        for (i = 0; i <= ADDRSIZE; i++) begin : g_g2b
            assign wbin[i] = ^(bus.rq2_wptr >> i);
        end
    endgenerate
    assign pop            = bus.dout_valid && bus.dout_ready;
    assign bus.dout_valid = state != EMPTY;
    assign bus.dout       = head;
    assign bus.raddr      = rbin[ADDRSIZE-1:0];
    // fetch while buffered plus in-flight words stay below two, or a pop frees a slot
    assign bus.ren        = !bus.rempty && (state == EMPTY || (state == ONE && !pend) || pop);
    assign rbin_next      = rbin + {{ADDRSIZE{1'b0}}, bus.ren};
    assign rgray_next     = rbin_next ^ (rbin_next >> 1);
    always_comb begin
        after_pop = state;
        if (pop) after_pop = (state == TWO) ? ONE : EMPTY;
        state_n = after_pop;
        if (pend) state_n = (after_pop == EMPTY) ? ONE : TWO;
        head_n = (pop && state == TWO) ? skid : head;
        skid_n = skid;
        if (pend && after_pop == EMPTY) head_n = bus.rdata_mem;
        if (pend && after_pop != EMPTY) skid_n = bus.rdata_mem;
    end
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) state <= EMPTY;
        else state <= state_n;
    end
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin       <= '0;
            bus.rptr   <= '0;
            bus.rempty <= 1'b1;
            bus.rlevel <= '0;
            pend       <= 1'b0;
            head       <= '0;
            skid       <= '0;
        end else begin
            rbin       <= rbin_next;
            bus.rptr   <= rgray_next;
            bus.rempty <= rgray_next == bus.rq2_wptr;
            bus.rlevel <= wbin - rbin_next;
            pend       <= bus.ren;
            head       <= head_n;
            skid       <= skid_n;
        end
    end
endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb_fifo_rd_ctrl: directed and random-ready scoreboard bench for fifo_rd_ctrl
module tb_fifo_rd_ctrl;
    localparam int A = 4;
    localparam int D = 8;
    logic rclk = 1'b0;
    logic rrst_n = 1'b0;
    always #5 rclk = ~rclk;
    fifo_rd_ctrl_if #(.ADDRSIZE(A), .DATASIZE(D)) bus ();
    fifo_rd_ctrl #(.ADDRSIZE(A), .DATASIZE(D)) dut (.rclk(rclk), .rrst_n(rrst_n), .bus(bus));
    logic [D-1:0] mem [2**A];
    logic [A:0]   wbin;
    logic [A:0]   diff;
    logic [D-1:0] q [$];
    int checks = 0, errors = 0, rens = 0, pops = 0, written = 0, cyc = 0;
    always @(posedge rclk) if (bus.ren) bus.rdata_mem <= mem[bus.raddr];
    function automatic logic [A:0] g2b(input logic [A:0] g);
        logic [A:0] b;
        b[A] = g[A];
        for (int k = A - 1; k >= 0; k--) b[k] = b[k+1] ^ g[k];
        return b;
    endfunction
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic put(input logic [D-1:0] d);
        mem[wbin[A-1:0]] = d;
        q.push_back(d);
        wbin = wbin + 1'b1;
        bus.rq2_wptr = wbin ^ (wbin >> 1);
    endtask
    task automatic tick();
        #1;
        if (bus.rempty) chk("ren_while_empty", {31'b0, bus.ren}, 0);
        if (bus.ren) rens++;
        if (bus.dout_valid && bus.dout_ready) begin
            pops++;
            chk("pop_nonempty", {31'b0, q.size() > 0}, 1);
            if (q.size() > 0) chk("pop_data", {24'b0, bus.dout}, {24'b0, q.pop_front()});
        end
        @(negedge rclk);
    endtask
    task automatic do_reset();
        rrst_n = 1'b0;
        wbin = '0;
        bus.rq2_wptr = '0;
        bus.dout_ready = 1'b0;
        q.delete();
        repeat (3) begin
            tick();
            chk("rst_rempty", {31'b0, bus.rempty}, 1);
            chk("rst_valid", {31'b0, bus.dout_valid}, 0);
            chk("rst_rptr", {27'b0, bus.rptr}, 0);
            chk("rst_rlevel", {27'b0, bus.rlevel}, 0);
            chk("rst_ren", {31'b0, bus.ren}, 0);
        end
        rrst_n = 1'b1;
    endtask
    initial begin
        wbin = '0;
        bus.rq2_wptr = '0;
        bus.dout_ready = 1'b0;
        @(negedge rclk);
        do_reset();
        // single word: three-edge latency
        put(8'hA5);
        bus.dout_ready = 1'b1;
        #1 chk("e0_rempty", {31'b0, bus.rempty}, 1);
        tick();
        chk("e1_rempty", {31'b0, bus.rempty}, 0);
        chk("e1_ren", {31'b0, bus.ren}, 1);
        chk("e1_valid", {31'b0, bus.dout_valid}, 0);
        chk("e1_rlevel", {27'b0, bus.rlevel}, 1);
        tick();
        chk("e2_rempty", {31'b0, bus.rempty}, 1);
        chk("e2_rptr", {27'b0, bus.rptr}, 1);
        chk("e2_raddr", {28'b0, bus.raddr}, 1);
        chk("e2_ren", {31'b0, bus.ren}, 0);
        chk("e2_valid", {31'b0, bus.dout_valid}, 0);
        tick();
        chk("e3_valid", {31'b0, bus.dout_valid}, 1);
        chk("e3_dout", {24'b0, bus.dout}, 32'hA5);
        pops = 0;
        tick();
        chk("e4_pops", pops, 1);
        chk("e4_valid", {31'b0, bus.dout_valid}, 0);
        // sixteen words with consumer stalled, then full-rate drain
        do_reset();
        rens = 0;
        for (int k = 0; k < 16; k++) put(8'($urandom));
        repeat (4) tick();
        chk("fill_dout_a", {24'b0, bus.dout}, {24'b0, q[0]});
        repeat (4) tick();
        chk("fill_rens", rens, 2);
        chk("fill_rlevel", {27'b0, bus.rlevel}, 14);
        chk("fill_valid", {31'b0, bus.dout_valid}, 1);
        chk("fill_dout_b", {24'b0, bus.dout}, {24'b0, q[0]});
        bus.dout_ready = 1'b1;
        pops = 0;
        for (int k = 0; k < 16; k++) begin
            chk("drain_valid", {31'b0, bus.dout_valid}, 1);
            tick();
        end
        chk("drain_pops", pops, 16);
        chk("drain_valid_end", {31'b0, bus.dout_valid}, 0);
        chk("drain_rempty", {31'b0, bus.rempty}, 1);
        chk("drain_rlevel", {27'b0, bus.rlevel}, 0);
        chk("drain_rptr", {27'b0, bus.rptr}, {27'b0, bus.rq2_wptr});
        // forty words with random back-pressure, pointers wrap
        pops = 0;
        written = 0;
        cyc = 0;
        while ((written < 40 || q.size() > 0) && cyc < 3000) begin
            diff = wbin - g2b(bus.rptr);
            if (written < 40 && diff < 5'd16 && $urandom_range(0, 1) == 1) begin
                put(8'(written * 7 + 3));
                written++;
            end
            bus.dout_ready = 1'($urandom_range(0, 1));
            tick();
            cyc++;
        end
        chk("wrap_timeout", {31'b0, cyc >= 3000}, 0);
        bus.dout_ready = 1'b1;
        repeat (3) tick();
        chk("wrap_pops", pops, 40);
        chk("wrap_rempty", {31'b0, bus.rempty}, 1);
        chk("wrap_valid", {31'b0, bus.dout_valid}, 0);
        chk("wrap_rlevel", {27'b0, bus.rlevel}, 0);
        chk("wrap_rptr", {27'b0, bus.rptr}, {27'b0, bus.rq2_wptr});
        // asynchronous reset with a word held and one in flight
        do_reset();
        for (int k = 0; k < 16; k++) put(8'(k + 8'h40));
        repeat (3) tick();
        chk("pre_rst_valid", {31'b0, bus.dout_valid}, 1);
        chk("pre_rst_dout", {24'b0, bus.dout}, 32'h40);
        rrst_n = 1'b0;
        #1;
        chk("arst_rempty", {31'b0, bus.rempty}, 1);
        chk("arst_valid", {31'b0, bus.dout_valid}, 0);
        chk("arst_dout", {24'b0, bus.dout}, 0);
        chk("arst_rptr", {27'b0, bus.rptr}, 0);
        chk("arst_raddr", {28'b0, bus.raddr}, 0);
        chk("arst_rlevel", {27'b0, bus.rlevel}, 0);
        chk("arst_ren", {31'b0, bus.ren}, 0);
        wbin = '0;
        bus.rq2_wptr = '0;
        q.delete();
        @(negedge rclk);
        rrst_n = 1'b1;
        bus.dout_ready = 1'b1;
        pops = 0;
        repeat (5) tick();
        chk("post_rst_stale", pops, 0);
        chk("post_rst_valid", {31'b0, bus.dout_valid}, 0);
        put(8'h3C);
        repeat (5) tick();
        chk("post_rst_pops", pops, 1);
        chk("post_rst_rempty", {31'b0, bus.rempty}, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
